// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller: FSM states, LFSR taps,
// flush vector and the LFSR step function used by both generator and MISR.
package s27_bist_pkg;

  localparam int unsigned SIG_W = 16;

  // x^16+x^14+x^13+x^11+1 -> feedback from bits 15,13,12,10
  localparam logic [SIG_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [SIG_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Packed as {G3,G2,G1,G0}
  localparam logic [3:0] FLUSH_VEC = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_CMP,
    ST_DONE
  } state_e;

  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] v, input logic sin);
    return {v[SIG_W-2:0], (^(v & LFSR_TAPS)) ^ sin};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and an optional serial input,
// usable as a pattern generator (serial input masked) or as a MISR.
module lfsr16
  import s27_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic             sin,
  input  logic             sin_en,
  output logic [SIG_W-1:0] q
);

  logic [SIG_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = lfsr_step(q_q, sin & sin_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 core: flushes the core, applies pseudo-random
// vectors, compacts G17 into a 16-bit MISR and compares against a golden value.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int unsigned      NPAT_W       = 8,
  parameter int unsigned      FLUSH_CYCLES = 3,
  parameter logic [SIG_W-1:0] SEED         = DEFAULT_SEED
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [NPAT_W-1:0] npat,
  input  logic [SIG_W-1:0]  golden,
  input  logic              G17,
  output logic              G0,
  output logic              G1,
  output logic              G2,
  output logic              G3,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [NPAT_W-1:0] FLUSH_LAST = NPAT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [NPAT_W-1:0] cnt_q, cnt_d;
  logic [NPAT_W-1:0] npat_q, npat_d;
  logic [3:0]        pins_q, pins_d;
  logic              pass_q, pass_d;
  logic              lfsr_load, lfsr_en;
  logic [SIG_W-1:0]  pat_q, pat_step, misr_q;

  lfsr16 #(.RST_VAL(SEED)) u_pat (
    .clk(CK), .rst(RST), .load(lfsr_load), .seed(SEED), .en(lfsr_en),
    .sin(1'b0), .sin_en(1'b0), .q(pat_q)
  );

  lfsr16 #(.RST_VAL('0)) u_misr (
    .clk(CK), .rst(RST), .load(lfsr_load), .seed('0), .en(lfsr_en),
    .sin(G17), .sin_en(1'b1), .q(misr_q)
  );

  assign pat_step = lfsr_step(pat_q, 1'b0);

  // Pins are loaded with the vector for the coming state, so during RUN the
  // pins always equal pat_q[3:0] in the same cycle G17 is compacted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    npat_d    = npat_q;
    pins_d    = FLUSH_VEC;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          npat_d    = npat;
          cnt_d     = '0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d = '0;
          if (npat_q != '0) begin
            state_d = ST_RUN;
            pins_d  = pat_q[3:0];
          end else begin
            state_d = ST_CMP;
          end
        end
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == npat_q - 1'b1) state_d = ST_CMP;
        else                        pins_d  = pat_step[3:0];
      end
      ST_CMP: begin
        pass_d  = (misr_q == golden);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      npat_q  <= '0;
      pins_q  <= FLUSH_VEC;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      pins_q  <= pins_d;
      pass_q  <= pass_d;
    end
  end

  assign {G3, G2, G1, G0} = pins_q;
  assign busy      = (state_q == ST_FLUSH) || (state_q == ST_RUN) || (state_q == ST_CMP);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl with a behavioural s27 core whose flip-flops start
// from an arbitrary state and can be scrambled at will.
module tb_s27_bist_ctrl;

  logic        CK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  npat;
  logic [15:0] golden;
  logic        G17;
  logic        G0, G1, G2, G3;
  logic        busy, done, pass;
  logic [15:0] signature;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] pin_log[$];

  // s27 core: state {G5,G6,G7}
  logic [2:0] core_s, core_next;
  logic       scramble_req;
  logic [2:0] scramble_val;

  // Returns {G17, next {G5,G6,G7}} for state s and pins p = {G3,G2,G1,G0}
  function automatic logic [3:0] core_eval(input logic [2:0] s, input logic [3:0] p);
    logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
    {g5, g6, g7} = s;
    g14 = ~p[0];
    g8  = g14 & g6;
    g12 = ~(p[1] | g7);
    g15 = g12 | g8;
    g16 = p[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(p[2] | g12);
    return {~g11, g10, g11, g13};
  endfunction

  function automatic logic [15:0] ref_sig(input int n);
    logic [15:0] pat, m;
    logic [2:0]  s;
    logic [3:0]  r;
    pat = 16'hACE1;
    m   = '0;
    s   = 3'b010;
    for (int i = 0; i < n; i++) begin
      r   = core_eval(s, pat[3:0]);
      m   = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10] ^ r[3]};
      pat = {pat[14:0], pat[15] ^ pat[13] ^ pat[12] ^ pat[10]};
      s   = r[2:0];
    end
    return m;
  endfunction

  assign {G17, core_next} = core_eval(core_s, {G3, G2, G1, G0});

  always @(posedge CK) begin
    if (scramble_req) core_s <= scramble_val;
    else              core_s <= core_next;
  end

  s27_bist_ctrl #(.NPAT_W(8), .FLUSH_CYCLES(3), .SEED(16'hACE1)) dut (
    .CK(CK), .RST(RST), .start(start), .npat(npat), .golden(golden), .G17(G17),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always #5 CK = ~CK;

  task automatic run_watch(input logic [7:0] n, input logic [15:0] gold,
                           output int busy_cnt, output int done_cnt);
    pin_log.delete();
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge CK);
    start = 1'b1; npat = n; golden = gold;
    @(negedge CK);
    start = 1'b0;
    for (int k = 0; k < int'(n) + 20; k++) begin
      if (busy) begin
        busy_cnt++;
        pin_log.push_back({G3, G2, G1, G0});
      end
      if (done) begin
        done_cnt++;
        break;
      end
      @(negedge CK);
    end
  endtask

  task automatic scramble_core(input logic [2:0] v);
    @(negedge CK);
    scramble_req = 1'b1; scramble_val = v;
    @(negedge CK);
    scramble_req = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b0; npat = '0; golden = '0;
    scramble_req = 1'b1; scramble_val = 3'($urandom_range(0, 7));
    repeat (2) @(negedge CK);
    RST = 1'b0; scramble_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      n_cmp++; if ({G0, G1, G2, G3} !== 4'b0011) begin n_bad++; $display("FAIL reset_pins: got %b expected 0011", {G0, G1, G2, G3}); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b expected 0", pass); end
      n_cmp++; if (signature !== 16'h0000) begin n_bad++; $display("FAIL reset_sig: got %h expected 0000", signature); end
    end
  endtask

  task automatic test_zero_patterns;
    int bc, dc;
    run_watch(8'd0, 16'h0000, bc, dc);
    n_cmp++; if (bc !== 4) begin n_bad++; $display("FAIL zero_busy_len: got %0d expected 4", bc); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL zero_done: got %0d expected 1", dc); end
    foreach (pin_log[i]) begin
      n_cmp++; if (pin_log[i] !== 4'b1100) begin n_bad++; $display("FAIL zero_pins[%0d]: got %h expected c", i, pin_log[i]); end
    end
    n_cmp++; if (signature !== 16'h0000) begin n_bad++; $display("FAIL zero_sig: got %h expected 0000", signature); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL zero_pass: got %b expected 1", pass); end
    @(negedge CK);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_patterns4;
    int bc, dc;
    logic [3:0] exp_v [4];
    exp_v = '{4'h1, 4'h3, 4'h7, 4'hF};
    run_watch(8'd4, 16'h000F, bc, dc);
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL p4_busy_len: got %0d expected 8", bc); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL p4_done: got %0d expected 1", dc); end
    n_cmp++;
    if (pin_log.size() != 8) begin
      n_bad++; $display("FAIL p4_pin_count: got %0d expected 8", pin_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (pin_log[i] !== 4'hC) begin n_bad++; $display("FAIL p4_flush_pins[%0d]: got %h expected c", i, pin_log[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (pin_log[3+i] !== exp_v[i]) begin n_bad++; $display("FAIL p4_run_pins[%0d]: got %h expected %h", i, pin_log[3+i], exp_v[i]); end
      end
      n_cmp++; if (pin_log[7] !== 4'hC) begin n_bad++; $display("FAIL p4_cmp_pins: got %h expected c", pin_log[7]); end
    end
    n_cmp++; if (signature !== 16'h000F) begin n_bad++; $display("FAIL p4_sig: got %h expected 000f", signature); end
    n_cmp++; if (signature !== ref_sig(4)) begin n_bad++; $display("FAIL p4_sig_model: got %h expected %h", signature, ref_sig(4)); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL p4_pass: got %b expected 1", pass); end
    run_watch(8'd4, 16'h000E, bc, dc);
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL p4_fail_pass: got %b expected 0", pass); end
    n_cmp++; if (signature !== 16'h000F) begin n_bad++; $display("FAIL p4_fail_sig: got %h expected 000f", signature); end
  endtask

  task automatic test_start_ignored;
    int bc = 0, dc = 0;
    @(negedge CK);
    start = 1'b1; npat = 8'd4; golden = 16'h000F;
    @(negedge CK);
    for (int k = 1; k <= 20; k++) begin
      if (busy) bc++;
      if (done) dc++;
      if (k == 2 || k == 5 || done) begin
        start = 1'b1; npat = 8'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge CK);
    end
    start = 1'b0;
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL ign_busy_len: got %0d expected 8", bc); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL ign_done: got %0d expected 1", dc); end
    n_cmp++; if (signature !== 16'h000F) begin n_bad++; $display("FAIL ign_sig: got %h expected 000f", signature); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL ign_pass: got %b expected 1", pass); end
  endtask

  task automatic test_reset_mid_run;
    int bc, dc;
    logic [15:0] exp_sig;
    exp_sig = ref_sig(255);
    @(negedge CK);
    start = 1'b1; npat = 8'd255; golden = exp_sig;
    @(negedge CK);
    start = 1'b0;
    repeat (5) @(negedge CK);
    RST = 1'b1;
    #1;
    n_cmp++; if ({G0, G1, G2, G3} !== 4'b0011) begin n_bad++; $display("FAIL rst_run_pins: got %b expected 0011", {G0, G1, G2, G3}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_run_busy: got %b expected 0", busy); end
    n_cmp++; if (signature !== 16'h0000) begin n_bad++; $display("FAIL rst_run_sig: got %h expected 0000", signature); end
    @(negedge CK);
    RST = 1'b0;
    scramble_core(3'b101);
    run_watch(8'd255, exp_sig, bc, dc);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL rst_rerun_done: got %0d expected 1", dc); end
    n_cmp++; if (signature !== exp_sig) begin n_bad++; $display("FAIL rst_rerun_sig: got %h expected %h", signature, exp_sig); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL rst_rerun_pass: got %b expected 1", pass); end
  endtask

  task automatic test_back_to_back;
    int bc, dc;
    logic [15:0] exp_sig;
    exp_sig = ref_sig(255);
    scramble_core(3'b111);
    run_watch(8'd255, exp_sig, bc, dc);
    n_cmp++; if (bc !== 259) begin n_bad++; $display("FAIL b2b_busy_len: got %0d expected 259", bc); end
    n_cmp++; if (signature !== exp_sig) begin n_bad++; $display("FAIL b2b_sig1: got %h expected %h", signature, exp_sig); end
    n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass1: got %b expected 1", pass); end
    run_watch(8'd255, exp_sig ^ 16'h0001, bc, dc);
    n_cmp++; if (signature !== exp_sig) begin n_bad++; $display("FAIL b2b_sig2: got %h expected %h", signature, exp_sig); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL b2b_pass2: got %b expected 0", pass); end
    @(negedge CK);
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL b2b_pass_hold: got %b expected 0", pass); end
  endtask

  initial begin
    test_reset();
    test_zero_patterns();
    test_patterns4();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
